// File: rtl/scan_link_pkg.sv
// Shared definitions for the scanner serial transfer link.
// The state encoding matches the scanner's ps debug decode, so both ends agree on what 00/01/10 mean.
package scan_link_pkg;

    // Link state encoding, shared with the scanner debug decode
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECV = 2'b01,
        HOLD = 2'b10
    } scan_state_t;

    // Default serial word width; matches the scanner data buffer
    localparam int SCAN_WORD_W = 4;

    // clkIn edge convention: a rising edge is the current sample high while the
    // one-cycle-delayed copy is still low. Data is taken in that same cycle.
    function automatic logic rising_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/scan_rx_fifo.sv
// Small word FIFO between the serial receiver and the local reader.
// Head word is read combinationally from the registered array. A push into a full
// FIFO only succeeds when a pop happens in the same cycle.
module scan_rx_fifo #(
    parameter int WORD_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WORD_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [WORD_W-1:0]          o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_pop_ok;
    logic              w_push_ok;
    logic [DEPTH-1:0]  w_we;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    // Per-slot write enables decoded from the write pointer
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign w_we[gi] = w_push_ok & (r_wr_ptr == AW'(gi));
        end
    endgenerate

    // Storage array; cleared on reset so the head reads zero while empty after reset
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= i_data;
                end
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/scan_receiver.sv
// Receiving end of the scanner serial link: detects clkIn rising edges, shifts dataIn
// MSB-first into WORD_W-bit words, buffers them in a FIFO and throttles the scanner
// through readyForTransfer. Partial words are dropped on timeout or early doneIn.
module scan_receiver
    import scan_link_pkg::*;
#(
    parameter int WORD_W  = SCAN_WORD_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clkIn,
    input  logic                       dataIn,
    input  logic                       doneIn,
    input  logic                       rdEn,
    input  logic                       clrErr,
    output logic                       readyForTransfer,
    output logic [WORD_W-1:0]          wordOut,
    output logic                       wordValid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       frameErr,
    output logic [1:0]                 ps
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT);

    // Registered state
    scan_state_t         r_ps;
    logic                r_clk_in_q;
    logic [WORD_W-1:0]   r_shift;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_push;
    logic [WORD_W-1:0]   r_push_word;
    logic                r_ready;
    logic                r_overflow;
    logic                r_frame_err;

    // Combinational next values and strobes
    scan_state_t         w_ps_next;
    logic [WORD_W-1:0]   w_shift_next;
    logic [BIT_W-1:0]    w_bit_cnt_next;
    logic [TMO_W-1:0]    w_tmo_next;
    logic                w_push_next;
    logic                w_frame_set;
    logic                w_edge;
    logic [WORD_W-1:0]   w_shifted;

    // FIFO interface
    logic [WORD_W-1:0]   w_head;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    logic                w_ovf_set;

    assign w_edge    = rising_edge(clkIn, r_clk_in_q);
    assign w_shifted = {r_shift[WORD_W-2:0], dataIn};

    // Next-state and datapath decode for the receive FSM
    always_comb begin
        w_ps_next      = r_ps;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_tmo_next     = r_tmo;
        w_push_next    = 1'b0;
        w_frame_set    = 1'b0;

        case (r_ps)
            IDLE, HOLD: begin
                // An edge in HOLD is the first bit of the next word, so nothing is lost
                w_tmo_next = '0;
                if (w_edge) begin
                    w_shift_next   = w_shifted;
                    w_bit_cnt_next = BIT_W'(1);
                    w_ps_next      = RECV;
                end else begin
                    w_bit_cnt_next = '0;
                    w_ps_next      = IDLE;
                end
            end
            RECV: begin
                if (w_edge && (r_bit_cnt == BIT_W'(WORD_W - 1))) begin
                    // Final bit: the completed word wins even if doneIn arrives with it
                    w_shift_next   = w_shifted;
                    w_bit_cnt_next = '0;
                    w_tmo_next     = '0;
                    w_push_next    = 1'b1;
                    w_ps_next      = HOLD;
                end else if (doneIn) begin
                    w_bit_cnt_next = '0;
                    w_tmo_next     = '0;
                    w_frame_set    = 1'b1;
                    w_ps_next      = IDLE;
                end else if (w_edge) begin
                    w_shift_next   = w_shifted;
                    w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
                    w_tmo_next     = '0;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_bit_cnt_next = '0;
                    w_tmo_next     = '0;
                    w_frame_set    = 1'b1;
                    w_ps_next      = IDLE;
                end else begin
                    w_tmo_next     = r_tmo + TMO_W'(1);
                end
            end
            default: begin
                w_ps_next      = IDLE;
                w_bit_cnt_next = '0;
                w_tmo_next     = '0;
            end
        endcase
    end

    // State register plus shifter, counters and the one-cycle-delayed push
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ps        <= IDLE;
            r_clk_in_q  <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tmo       <= '0;
            r_push      <= 1'b0;
            r_push_word <= '0;
        end else begin
            r_ps        <= w_ps_next;
            r_clk_in_q  <= clkIn;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_tmo       <= w_tmo_next;
            r_push      <= w_push_next;
            if (w_push_next) begin
                r_push_word <= w_shift_next;
            end
        end
    end

    scan_rx_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (rst),
        .i_push  (r_push),
        .i_data  (r_push_word),
        .i_pop   (rdEn),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A word is dropped only when full and no pop frees a slot in the same cycle
    assign w_ovf_set = r_push & w_full & ~(rdEn & ~w_empty);

    // Sticky error flags and the registered throttle back to the scanner; set beats clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clrErr) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (clrErr) begin
                r_frame_err <= 1'b0;
            end
            r_ready <= (r_ps == IDLE) && (w_count < CNT_W'(DEPTH));
        end
    end

    assign readyForTransfer = r_ready;
    assign wordOut          = w_head;
    assign wordValid        = ~w_empty;
    assign count            = w_count;
    assign overflow         = r_overflow;
    assign frameErr         = r_frame_err;
    assign ps               = r_ps;

endmodule

// File: tb/tb_scan_receiver.sv
// Directed bench for scan_receiver: serial words driven as 2-high/6-low clkIn pulses,
// outputs sampled 1 time unit after the rising clk edge.
module tb_scan_receiver;

    localparam int WORD_W  = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        clkIn  = 1'b0;
    logic        dataIn = 1'b0;
    logic        doneIn = 1'b0;
    logic        rdEn   = 1'b0;
    logic        clrErr = 1'b0;
    logic        readyForTransfer;
    logic [3:0]  wordOut;
    logic        wordValid;
    logic [2:0]  count;
    logic        overflow;
    logic        frameErr;
    logic [1:0]  ps;

    int n_checks = 0;
    int n_errors = 0;

    scan_receiver #(
        .WORD_W  (WORD_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clkIn            (clkIn),
        .dataIn           (dataIn),
        .doneIn           (doneIn),
        .rdEn             (rdEn),
        .clrErr           (clrErr),
        .readyForTransfer (readyForTransfer),
        .wordOut          (wordOut),
        .wordValid        (wordValid),
        .count            (count),
        .overflow         (overflow),
        .frameErr         (frameErr),
        .ps               (ps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One serial bit; side 1 pulses rdEn and side 2 pulses doneIn in the cycle after the edge
    task automatic send_bit(input logic b, input int side);
        clkIn  = 1'b1;
        dataIn = b;
        tick(1);
        if (side == 1) rdEn = 1'b1;
        if (side == 2) doneIn = 1'b1;
        tick(1);
        rdEn   = 1'b0;
        doneIn = 1'b0;
        clkIn  = 1'b0;
        tick(6);
    endtask

    task automatic send_word(input logic [3:0] w, input int side);
        for (int i = 3; i >= 0; i--) begin
            send_bit(w[i], (i == 0) ? side : 0);
        end
        $display("word 0x%h sent side=%0d count=%0d ovf=%0d", w, side, count, overflow);
    endtask

    task automatic pop_chk(input logic [3:0] exp, input string tag);
        chk(tag, wordOut, exp);
        chk({tag, "_valid"}, wordValid, 1);
        rdEn = 1'b1;
        tick(1);
        rdEn = 1'b0;
        $display("pop expected 0x%h count now %0d", exp, count);
    endtask

    task automatic clear_flags();
        clrErr = 1'b1;
        tick(1);
        clrErr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles
        tick(2);
        chk("rst_ps", ps, 2'b00);
        chk("rst_count", count, 0);
        chk("rst_valid", wordValid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frameErr, 0);
        chk("rst_ready", readyForTransfer, 0);
        chk("rst_word", wordOut, 0);
        rst = 1'b1;
        tick(1);
        chk("ready_after_rst", readyForTransfer, 1);
        $display("reset done");

        // Single word 1011 with exact push latency
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        clkIn  = 1'b1;
        dataIn = 1'b1;
        tick(1);
        chk("single_hold", ps, 2'b10);
        chk("single_valid_early", wordValid, 0);
        tick(1);
        chk("single_valid", wordValid, 1);
        chk("single_word", wordOut, 4'hB);
        chk("single_count", count, 1);
        clkIn = 1'b0;
        tick(6);
        $display("word 0xb sent count=%0d", count);
        pop_chk(4'hB, "single_pop");
        chk("single_count_after", count, 0);

        // Fill then overflow
        for (int w = 1; w <= 4; w++) send_word(4'(w), 0);
        chk("fill_ready", readyForTransfer, 0);
        chk("fill_count", count, 4);
        chk("fill_ovf_pre", overflow, 0);
        send_word(4'h5, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 4);
        pop_chk(4'h1, "ovf_pop1");
        pop_chk(4'h2, "ovf_pop2");
        pop_chk(4'h3, "ovf_pop3");
        pop_chk(4'h4, "ovf_pop4");
        chk("ovf_empty", wordValid, 0);
        chk("ovf_still_set", overflow, 1);
        clear_flags();
        chk("ovf_clr", overflow, 0);

        // Push and pop together while full
        for (int w = 1; w <= 4; w++) send_word(4'(w), 0);
        send_word(4'h5, 1);
        chk("pp_ovf", overflow, 0);
        chk("pp_count", count, 4);
        pop_chk(4'h2, "pp_pop2");
        pop_chk(4'h3, "pp_pop3");
        pop_chk(4'h4, "pp_pop4");
        pop_chk(4'h5, "pp_pop5");
        chk("pp_count_end", count, 0);

        // doneIn during HOLD is a clean end of transfer
        send_word(4'h6, 2);
        chk("hold_done_ferr", frameErr, 0);
        chk("hold_done_count", count, 1);
        pop_chk(4'h6, "hold_done_pop");

        // Timeout: the error lands exactly 32 cycles after the last edge
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        tick(24);
        chk("tmo_not_yet", frameErr, 0);
        chk("tmo_ps_recv", ps, 2'b01);
        tick(1);
        chk("tmo_ferr", frameErr, 1);
        chk("tmo_ps", ps, 2'b00);
        tick(15);
        chk("tmo_count", count, 0);
        $display("timeout observed frameErr=%0d", frameErr);
        clear_flags();
        chk("tmo_clr", frameErr, 0);

        // doneIn after 3 bits, coinciding with clrErr: the set wins
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        chk("pd_recv", ps, 2'b01);
        doneIn = 1'b1;
        clrErr = 1'b1;
        tick(1);
        doneIn = 1'b0;
        clrErr = 1'b0;
        chk("pd_ferr", frameErr, 1);
        chk("pd_ps", ps, 2'b00);
        chk("pd_count", count, 0);
        $display("partial word aborted by doneIn");
        clear_flags();
        chk("pd_clr", frameErr, 0);

        // Reset in the middle of a word, then a clean word
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        rst = 1'b0;
        tick(1);
        chk("mr_ps", ps, 2'b00);
        chk("mr_count", count, 0);
        chk("mr_ready", readyForTransfer, 0);
        rst = 1'b1;
        tick(1);
        send_word(4'hA, 0);
        chk("mr_word", wordOut, 4'hA);
        chk("mr_count_after", count, 1);
        chk("mr_ferr", frameErr, 0);
        pop_chk(4'hA, "mr_pop");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
